adc_i2c_reader: RTL and testbench



---
 rtl/adc_i2c_reader.sv | 158 +++++++++++++++
 tb/tb_adc_i2c_reader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_i2c_reader.sv
// I2C-style master that repeatedly reads one 8-bit sample from a serial ADC.
// Optional macro ADC_ACK_CHECK_EN: a NACKed address skips READ and goes straight to STOP.
module adc_i2c_reader #(
    parameter int         CLK_DIV    = 4,
    parameter logic [6:0] ADC_ADDR   = 7'h48,
    parameter int         GAP_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    inout  wire        SDA,
    output logic       SCL,
    output logic [7:0] DATA_out,
    output logic [7:0] TEST_STATE
);
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_ADDR  = 4'd2,
        S_TURN  = 4'd3,
        S_ACK   = 4'd4,
        S_READ  = 4'd5,
        S_NACK  = 4'd6,
        S_STOP  = 4'd7,
        S_GAP   = 4'd8
    } state_t;

    localparam int               PH_W      = $clog2(CLK_DIV);
    localparam int               GAP_W     = $clog2(GAP_CYCLES + 1);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_MID    = PH_W'(CLK_DIV / 2);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [7:0]       ADDR_BYTE = {ADC_ADDR, 1'b1};

    state_t           state_q, state_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic             half_q, half_d;
    logic [2:0]       bit_q, bit_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [6:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             scl_q, scl_d;
    logic             sda_low_q, sda_low_d;
    logic             half_end, bit_end;
    logic             sda_in;

    // The board pull-up turns a released line into a 1.
    assign sda_in     = SDA;
    assign SDA        = sda_low_q ? 1'b0 : 1'bz;
    assign SCL        = scl_q;
    assign DATA_out   = data_q;
    assign TEST_STATE = {4'b0000, state_q};

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        ph_d      = ph_q;
        half_d    = half_q;
        bit_d     = bit_q;
        gap_d     = gap_q;
        shift_d   = shift_q;
        data_d    = data_q;
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
        half_end  = (ph_q == PH_LAST);
        bit_end   = half_end && half_q;

        if (state_q != S_IDLE && state_q != S_GAP) begin
            ph_d = half_end ? '0 : ph_q + PH_W'(1);
            if (half_end) half_d = ~half_q;
        end

        case (state_q)
            S_IDLE:  state_d = S_START;
            S_START: if (bit_end) state_d = S_ADDR;
            S_ADDR: if (bit_end) begin
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = S_TURN;
            end
            S_TURN: if (half_end) begin
                half_d  = 1'b0;
                state_d = S_ACK;
            end
            S_ACK: if (bit_end) begin
`ifdef ADC_ACK_CHECK_EN
                state_d = sda_in ? S_STOP : S_READ;
`else
                state_d = S_READ;
`endif
            end
            S_READ: if (bit_end) begin
                shift_d = {shift_q[5:0], sda_in};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    data_d  = {shift_q, sda_in};
                    state_d = S_NACK;
                end
            end
            S_NACK: if (bit_end) state_d = S_STOP;
            S_STOP: if (bit_end) state_d = S_GAP;
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = S_START;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pin levels are decoded from the next state so they register alongside it.
        case (state_d)
            S_START: begin
                scl_d     = ~half_d;
                sda_low_d = 1'b1;
            end
            S_ADDR: begin
                scl_d     = half_d;
                sda_low_d = ~ADDR_BYTE[3'd7 - bit_d];
            end
            S_TURN:                 scl_d = 1'b0;
            S_ACK, S_READ, S_NACK:  scl_d = half_d;
            S_STOP: begin
                scl_d     = half_d;
                sda_low_d = ~half_d || (ph_d < PH_MID);
            end
            default: begin
                scl_d     = 1'b1;
                sda_low_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            ph_q      <= '0;
            half_q    <= 1'b0;
            bit_q     <= '0;
            gap_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            scl_q     <= 1'b1;
            sda_low_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q   <= state_d;
            ph_q      <= ph_d;
            half_q    <= half_d;
            bit_q     <= bit_d;
            gap_q     <= gap_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            scl_q     <= scl_d;
            sda_low_q <= sda_low_d;
        end
    end
endmodule

// File: tb/tb_adc_i2c_reader.sv
// Self-checking bench for adc_i2c_reader: bit-level transaction model, per-cycle compare, bus slave.
module tb_adc_i2c_reader;
    localparam int         CLK_DIV    = 4;
    localparam int         GAP_CYCLES = 16;
    localparam logic [6:0] ADC_ADDR   = 7'h48;
    localparam int         PERIOD     = 2 * CLK_DIV * 20 + GAP_CYCLES + CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       slave_low = 1'b0;
    wire        sda;
    logic       scl;
    logic [7:0] data_out;
    logic [7:0] test_state;

    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    adc_i2c_reader #(
        .CLK_DIV   (CLK_DIV),
        .ADC_ADDR  (ADC_ADDR),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .CLK       (clk),
        .RST       (rst_n),
        .SDA       (sda),
        .SCL       (scl),
        .DATA_out  (data_out),
        .TEST_STATE(test_state)
    );

    always #5 clk = ~clk;

    // One entry per system clock: what the pins must show after that clock edge.
    typedef struct {
        logic [7:0] state;
        logic       scl;
        logic       m_low;
        logic       s_low;
        logic       sda_dc;
        logic [7:0] data;
    } slot_t;

    slot_t exp_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    fail_prints = 0;
    int    txn_count = 0;
    logic  prev_scl = 1'b1;
    logic  prev_sda = 1'b1;

    // START-entry monitor: cycles between successive entries into state 1.
    int         cyc = 0;
    int         last_period = 0;
    int         starts = 0;
    logic [7:0] mon_prev_state = 8'd0;

    always @(negedge clk) begin
        cyc++;
        if (test_state == 8'd1 && mon_prev_state != 8'd1) begin
            last_period = cyc;
            cyc = 0;
            starts++;
        end
        mon_prev_state = test_state;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s @%0t: got %0h expected %0h", name, $time, actual, expected);
            end
        end
    endtask

    task automatic push(input int n, input int st, input logic c, input logic m,
                        input logic s, input logic dc, input logic [7:0] d);
        slot_t e;
        e.state = 8'(st);
        e.scl = c;
        e.m_low = m;
        e.s_low = s;
        e.sda_dc = dc;
        e.data = d;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    // ack_low: slave pulls SDA low during the ACK bit. Returns whether a read happened.
    task automatic build_txn(input logic ack_low, input logic [7:0] rd,
                             inout logic [7:0] cur, output logic read_ok);
        logic [7:0] ab;
        ab = {ADC_ADDR, 1'b1};
        push(CLK_DIV, 1, 1'b1, 1'b1, 1'b0, 1'b0, cur);
        push(CLK_DIV, 1, 1'b0, 1'b1, 1'b0, 1'b0, cur);
        for (int i = 7; i >= 0; i--) begin
            push(CLK_DIV, 2, 1'b0, !ab[i], 1'b0, 1'b0, cur);
            push(CLK_DIV, 2, 1'b1, !ab[i], 1'b0, 1'b0, cur);
        end
        push(CLK_DIV, 3, 1'b0, 1'b0, 1'b0, 1'b0, cur);
        push(CLK_DIV, 4, 1'b0, 1'b0, ack_low, 1'b0, cur);
        push(CLK_DIV, 4, 1'b1, 1'b0, ack_low, 1'b0, cur);
`ifdef ADC_ACK_CHECK_EN
        read_ok = ack_low;
`else
        read_ok = 1'b1;
`endif
        if (read_ok) begin
            for (int i = 7; i >= 0; i--) begin
                push(CLK_DIV, 5, 1'b0, 1'b0, !rd[i], 1'b0, cur);
                push(CLK_DIV, 5, 1'b1, 1'b0, !rd[i], 1'b0, cur);
            end
            cur = rd;
            push(CLK_DIV, 6, 1'b0, 1'b0, 1'b0, 1'b0, cur);
            push(CLK_DIV, 6, 1'b1, 1'b0, 1'b0, 1'b0, cur);
        end
        push(CLK_DIV, 7, 1'b0, 1'b1, 1'b0, 1'b0, cur);
        push(CLK_DIV, 7, 1'b1, 1'b0, 1'b0, 1'b1, cur);
        push(GAP_CYCLES, 8, 1'b1, 1'b0, 1'b0, 1'b0, cur);
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_state"}, test_state, 8'd0);
        check({tag, "_scl"}, scl, 1'b1);
        check({tag, "_sda"}, sda, 1'b1);
        check({tag, "_data"}, data_out, 8'h00);
    endtask

    // Plays the queued transaction cycle by cycle; abort_at >= 0 asserts reset at that entry.
    task automatic play(input logic check_period, input int abort_at, output logic aborted);
        slot_t      e;
        logic [7:0] addr_cap;
        int         addr_n;
        logic       start_seen;
        logic       stop_seen;
        int         idx;
        aborted = 1'b0;
        addr_cap = 8'h00;
        addr_n = 0;
        start_seen = 1'b0;
        stop_seen = 1'b0;
        idx = 0;
        txn_count++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            slave_low = e.s_low;
            #1;
            if (idx == 0 && check_period) check("start_period", last_period, PERIOD);
            check("state", test_state, e.state);
            check("scl", scl, e.scl);
            check("data_out", data_out, e.data);
            if (!e.sda_dc) check("sda", sda, !(e.m_low || e.s_low));
            if (prev_scl && scl && prev_sda && !sda && test_state == 8'd1) start_seen = 1'b1;
            if (prev_scl && scl && !prev_sda && sda && test_state == 8'd7) stop_seen = 1'b1;
            if (!prev_scl && scl && test_state == 8'd2) begin
                addr_cap = {addr_cap[6:0], sda};
                addr_n++;
            end
            prev_scl = scl;
            prev_sda = sda;
            if (idx == abort_at) begin
                #1;
                rst_n = 1'b0;
                slave_low = 1'b0;
                #1;
                check_reset_pins("async_rst");
                exp_q.delete();
                aborted = 1'b1;
                break;
            end
            idx++;
        end
        if (!aborted) begin
            check("start_edge", start_seen, 1'b1);
            check("addr_bits", addr_n, 8);
            check("addr_byte", addr_cap, 8'h91);
            check("stop_edge", stop_seen, 1'b1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] cur;
        logic       read_ok;
        logic       prev_full;
        logic       aborted;
        cur = 8'h00;
        prev_full = 1'b0;

        rst_n = 1'b0;
        slave_low = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            check_reset_pins("reset");
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_state", test_state, 8'd0);
        prev_scl = scl;
        prev_sda = sda;

        // Alternating full-scale data, then a released ACK, then 8'h55.
        build_txn(1'b1, 8'hFF, cur, read_ok);
        play(prev_full, -1, aborted);
        prev_full = read_ok;
        check("lit_ff", data_out, 8'hFF);

        build_txn(1'b1, 8'h00, cur, read_ok);
        play(prev_full, -1, aborted);
        prev_full = read_ok;
        check("lit_00", data_out, 8'h00);

        build_txn(1'b0, 8'h3C, cur, read_ok);
        play(prev_full, -1, aborted);
        prev_full = read_ok;
`ifdef ADC_ACK_CHECK_EN
        check("lit_nack_hold", data_out, 8'h00);
`else
        check("lit_3c", data_out, 8'h3C);
`endif

        build_txn(1'b1, 8'h55, cur, read_ok);
        play(prev_full, -1, aborted);
        prev_full = read_ok;
        check("lit_55", data_out, 8'h55);

        for (int t = 0; t < 6; t++) begin
            build_txn(1'($urandom_range(0, 1)), 8'($urandom), cur, read_ok);
            play(prev_full, -1, aborted);
            prev_full = read_ok;
        end

        // Reset in the middle of READ bit 3.
        build_txn(1'b1, 8'($urandom), cur, read_ok);
        play(prev_full, 21 * CLK_DIV + 6 * CLK_DIV + 1, aborted);
        check("abort_taken", aborted, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("recover_state", test_state, 8'd0);
        prev_scl = scl;
        prev_sda = sda;
        cur = 8'h00;
        prev_full = 1'b0;

        for (int t = 0; t < 2; t++) begin
            build_txn(1'b1, 8'($urandom), cur, read_ok);
            play(prev_full, -1, aborted);
            prev_full = read_ok;
        end

        check("start_count", starts, txn_count);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
